// File: rtl/commit_unit_mw_pkg.sv
`default_nettype none
// ============================================================================
// commit_unit_mw_pkg : instruction ids, widths and FSM encoding for commit
// Revision: 1.0
// ============================================================================
package commit_unit_mw_pkg;

    localparam int InstrIdWidth = 6;
    localparam int AddrWidth    = 32;
    localparam int InstrBytes   = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic ZERO  = 1'b0;

    // Ids are ordered so every class is a contiguous range
    localparam logic [InstrIdWidth-1:0] LB    = 6'd0;
    localparam logic [InstrIdWidth-1:0] LH    = 6'd1;
    localparam logic [InstrIdWidth-1:0] LW    = 6'd2;
    localparam logic [InstrIdWidth-1:0] LBU   = 6'd3;
    localparam logic [InstrIdWidth-1:0] LHU   = 6'd4;
    localparam logic [InstrIdWidth-1:0] SB    = 6'd5;
    localparam logic [InstrIdWidth-1:0] SH    = 6'd6;
    localparam logic [InstrIdWidth-1:0] SW    = 6'd7;
    localparam logic [InstrIdWidth-1:0] LUI   = 6'd8;
    localparam logic [InstrIdWidth-1:0] AUIPC = 6'd9;
    localparam logic [InstrIdWidth-1:0] JAL   = 6'd10;
    localparam logic [InstrIdWidth-1:0] JALR  = 6'd11;
    localparam logic [InstrIdWidth-1:0] BEQ   = 6'd12;
    localparam logic [InstrIdWidth-1:0] BNE   = 6'd13;
    localparam logic [InstrIdWidth-1:0] BLT   = 6'd14;
    localparam logic [InstrIdWidth-1:0] BGE   = 6'd15;
    localparam logic [InstrIdWidth-1:0] BLTU  = 6'd16;
    localparam logic [InstrIdWidth-1:0] BGEU  = 6'd17;
    localparam logic [InstrIdWidth-1:0] ADDI  = 6'd18;
    localparam logic [InstrIdWidth-1:0] AND   = 6'd36;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic logic id_in(input logic [InstrIdWidth-1:0] id,
                                   input logic [InstrIdWidth-1:0] lo,
                                   input logic [InstrIdWidth-1:0] hi);
        return (id >= lo) && (id <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/commit_lane_decode.sv
`default_nettype none
// ============================================================================
// commit_lane_decode : combinational classifier for one ROB-head lane
// Revision: 1.0
// ============================================================================
module commit_lane_decode
    import commit_unit_mw_pkg::*;
(
    input  logic [InstrIdWidth-1:0] instr_id,
    input  logic                    jump_en,
    input  logic                    bp,
    input  logic [AddrWidth-1:0]    jump_a,
    input  logic [AddrWidth-1:0]    pc,
    output logic                    wr_reg,
    output logic                    is_ctrl,
    output logic                    is_cond,
    output logic                    is_store,
    output logic                    mispred,
    output logic [AddrWidth-1:0]    target
);

    assign wr_reg   = (instr_id <= LHU) || id_in(instr_id, LUI, JALR) || (instr_id >= ADDI);
    assign is_ctrl  = id_in(instr_id, JAL, BGEU);
    assign is_cond  = is_ctrl && (instr_id >= BEQ);
    assign is_store = id_in(instr_id, SB, SW);
    assign mispred  = is_ctrl && (bp != jump_en);

    // Predicted taken but fell through: resume at the sequential successor
    assign target   = bp ? (pc + AddrWidth'(InstrBytes)) : jump_a;

endmodule
`default_nettype wire

// File: rtl/commit_unit_mw.sv
`default_nettype none
// ============================================================================
// commit_unit_mw : multi-width in-order retire with hazard-limited groups
// Revision: 1.0
// ============================================================================
module commit_unit_mw
    import commit_unit_mw_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   rdy_in,
    input  logic [COMMIT_WIDTH-1:0]                rob_valid_in,
    input  logic [COMMIT_WIDTH*InstrIdWidth-1:0]   instr_id_in,
    input  logic [COMMIT_WIDTH-1:0]                jump_en_in,
    input  logic [COMMIT_WIDTH-1:0]                bp_in,
    input  logic [COMMIT_WIDTH*AddrWidth-1:0]      jump_a_in,
    input  logic [COMMIT_WIDTH*AddrWidth-1:0]      pc_in,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]      rob_pop_cnt_out,
    output logic [COMMIT_WIDTH-1:0]                commit_to_regfile_en_out,
    output logic                                   commit_to_lsb_w_en_out,
    output logic                                   commit_to_pc_en_out,
    output logic [AddrWidth-1:0]                   commit_to_pc_out,
    output logic                                   commit_to_if_en_out,
    output logic [AddrWidth-1:0]                   commit_to_if_pc_out,
    output logic                                   commit_to_if_bpres_out,
    output logic                                   clear_branch_out,
    output logic [CNT_WIDTH-1:0]                   perf_commit_cnt_out,
    output logic [CNT_WIDTH-1:0]                   perf_branch_cnt_out,
    output logic [CNT_WIDTH-1:0]                   perf_mispred_cnt_out
);

    localparam int PopW      = $clog2(COMMIT_WIDTH + 1);
    localparam int FlushCntW = 3;

    logic [COMMIT_WIDTH-1:0] wr_reg_v;
    logic [COMMIT_WIDTH-1:0] is_ctrl_v;
    logic [COMMIT_WIDTH-1:0] is_cond_v;
    logic [COMMIT_WIDTH-1:0] is_store_v;
    logic [COMMIT_WIDTH-1:0] mispred_v;
    logic [AddrWidth-1:0]    target_v [COMMIT_WIDTH];

    genvar k;
    generate
        for (k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
            commit_lane_decode u_dec (
                .instr_id (instr_id_in[k*InstrIdWidth +: InstrIdWidth]),
                .jump_en  (jump_en_in[k]),
                .bp       (bp_in[k]),
                .jump_a   (jump_a_in[k*AddrWidth +: AddrWidth]),
                .pc       (pc_in[k*AddrWidth +: AddrWidth]),
                .wr_reg   (wr_reg_v[k]),
                .is_ctrl  (is_ctrl_v[k]),
                .is_cond  (is_cond_v[k]),
                .is_store (is_store_v[k]),
                .mispred  (mispred_v[k]),
                .target   (target_v[k])
            );
        end
    endgenerate

    state_t                 state, state_nxt;
    logic [FlushCntW-1:0]   flush_cnt, flush_cnt_nxt;

    logic [COMMIT_WIDTH-1:0] take;
    logic [PopW-1:0]         pop;
    logic                    stop;
    logic                    store_seen;

    // Contiguous prefix of valid lanes, cut after a control op or before a 2nd store
    always_comb begin
        take       = '0;
        pop        = '0;
        stop       = FALSE;
        store_seen = FALSE;
        if (state == IDLE && rdy_in) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (!stop) begin
                    if (!rob_valid_in[i] || (is_store_v[i] && store_seen)) begin
                        stop = TRUE;
                    end else begin
                        take[i]    = TRUE;
                        pop        = PopW'(i + 1);
                        store_seen = store_seen | is_store_v[i];
                        if (is_ctrl_v[i]) begin
                            stop = TRUE;
                        end
                    end
                end
            end
        end
    end

    assign rob_pop_cnt_out = pop;

    logic                 redirect;
    logic [AddrWidth-1:0] redirect_pc;
    logic                 upd;
    logic [AddrWidth-1:0] upd_pc;
    logic                 upd_res;
    logic                 st_rel;

    always_comb begin
        redirect    = FALSE;
        redirect_pc = '0;
        upd         = FALSE;
        upd_pc      = '0;
        upd_res     = FALSE;
        st_rel      = FALSE;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (take[i]) begin
                if (mispred_v[i]) begin
                    redirect    = TRUE;
                    redirect_pc = target_v[i];
                end
                if (is_cond_v[i]) begin
                    upd     = TRUE;
                    upd_pc  = pc_in[i*AddrWidth +: AddrWidth];
                    upd_res = jump_en_in[i];
                end
                if (is_store_v[i]) begin
                    st_rel = TRUE;
                end
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FlushCntW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (rdy_in) begin
                    if (flush_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign clear_branch_out = (state == FLUSH);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            commit_to_regfile_en_out <= '0;
            commit_to_lsb_w_en_out   <= ZERO;
            commit_to_pc_en_out      <= ZERO;
            commit_to_pc_out         <= '0;
            commit_to_if_en_out      <= ZERO;
            commit_to_if_pc_out      <= '0;
            commit_to_if_bpres_out   <= ZERO;
            perf_commit_cnt_out      <= '0;
            perf_branch_cnt_out      <= '0;
            perf_mispred_cnt_out     <= '0;
        end else begin
            commit_to_regfile_en_out <= take & wr_reg_v;
            commit_to_lsb_w_en_out   <= st_rel;
            commit_to_pc_en_out      <= redirect;
            commit_to_pc_out         <= redirect_pc;
            commit_to_if_en_out      <= upd;
            commit_to_if_pc_out      <= upd_pc;
            commit_to_if_bpres_out   <= upd_res;
            // take is empty when stalled or flushing, so these hold naturally
            perf_commit_cnt_out      <= perf_commit_cnt_out + CNT_WIDTH'(pop);
            perf_branch_cnt_out      <= perf_branch_cnt_out + CNT_WIDTH'(upd);
            perf_mispred_cnt_out     <= perf_mispred_cnt_out + CNT_WIDTH'(redirect);
        end
    end

endmodule
`default_nettype wire

// File: doc/commit_unit_mw.md
Name: commit_unit_mw

Overview:
Parametrised multi-width successor to the single-lane commit decoder. Retires up to COMMIT_WIDTH in-order instructions per cycle from the ROB head and stops the retire group at structural or control hazards. Registers all side-effect enables (regfile, LSB store release, PC redirect, IF predictor update) and runs a flush state machine on branch mispredict. Keeps wrap-around performance counters. Sits between ROB head and regfile/LSB/PC/IF.

Parameters:
COMMIT_WIDTH, 2, lanes inspected per cycle (1..4); lane 0 = ROB head
FLUSH_CYCLES, 1, cycles clear_branch_out stays high after a redirect (1..7)
CNT_WIDTH, 32, width of each performance counter

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  global ready; low = stall
rob_valid_in  input  COMMIT_WIDTH  lane k holds a ready-to-commit entry
instr_id_in  input  COMMIT_WIDTH*InstrIdWidth  per-lane instruction id
jump_en_in  input  COMMIT_WIDTH  per-lane resolved taken
bp_in  input  COMMIT_WIDTH  per-lane predicted taken
jump_a_in  input  COMMIT_WIDTH*AddrWidth  per-lane resolved target
pc_in  input  COMMIT_WIDTH*AddrWidth  per-lane instruction PC
rob_pop_cnt_out  output  clog2(COMMIT_WIDTH+1)  entries retired this cycle (combinational)
commit_to_regfile_en_out  output  COMMIT_WIDTH  per-lane regfile write-back enable (registered)
commit_to_lsb_w_en_out  output  1  release one store (registered)
commit_to_pc_en_out  output  1  PC redirect (registered)
commit_to_pc_out  output  AddrWidth  redirect target
commit_to_if_en_out  output  1  predictor update (registered)
commit_to_if_pc_out  output  AddrWidth  updated branch PC
commit_to_if_bpres_out  output  1  actual outcome
clear_branch_out  output  1  pipeline flush
perf_commit_cnt_out  output  CNT_WIDTH  retired instructions
perf_branch_cnt_out  output  CNT_WIDTH  retired conditional branches
perf_mispred_cnt_out  output  CNT_WIDTH  retired mispredicted JAL..BGEU

Behaviour:
- Reset (rst_in low, async): all outputs 0, FSM=IDLE, flush counter 0, perf counters 0.
- Per-lane decode uses the shared id ranges:
  - writes reg: id<=LHU, LUI..JALR, or >=ADDI
  - control: JAL..BGEU; conditional: >=BEQ within control
  - store: SB..SW
- Group selection (IDLE, rdy_in=1): retire lanes 0..n-1; lane k is included only if rob_valid_in[k] and every earlier lane was included. Group ends:
  - after the first control lane (max one control per group);
  - before a second store (max one store per group).
- rob_pop_cnt_out = n, combinational, same cycle. The ROB pops n entries at the clock edge.
- Registered outputs appear at cycle t+1 for a group selected at t. They are 1-cycle pulses, 0 when nothing was selected.
- Mispredict (control lane with bp!=jump_en):
  - pc_en=1 at t+1; target = bp ? pc+InstrBytes : jump_a.
  - FSM -> FLUSH; clear_branch_out=1 for FLUSH_CYCLES cycles starting t+1.
  - rob_pop_cnt_out forced 0 throughout FLUSH; then IDLE.
  - Correctly predicted control: no redirect, no flush.
- Conditional branch retired: if_en=1, if_pc=pc, bpres=jump_en (mispredicted or not).
- rdy_in=0: pop count 0; registered enables 0 next cycle; FSM, flush counter, perf counters hold.
- Counters increment by n / branch / mispredict at the retire edge and wrap modulo 2^CNT_WIDTH.
- Reset mid-FLUSH: immediate return to IDLE, clear_branch_out drops asynchronously.

Decomposition:
- Shared config header/package: instruction id constants (LB..ADDI ranges), InstrIdWidth, AddrWidth, InstrBytes, TRUE/FALSE/ZERO, FSM state encoding (IDLE, FLUSH).
- One sub-module, commit_lane_decode: purely combinational per-lane classifier (wr_reg, is_ctrl, is_cond, is_store, mispred, redirect target). Instantiated COMMIT_WIDTH times via generate.

Test Plan:
- Two valid ADDI lanes, W=2 -> pop=2; next cycle regfile_en=2'b11; perf_commit=2.
- Lane0 SW, lane1 SB -> pop=1, lsb_w_en=1 next cycle; second cycle pops SB, lsb_w_en=1 again.
- Lane0 BEQ at pc=0x100, bp=1, jump_en=0; lane1 ADDI -> pop=1; next cycle pc_en=1, pc_out=0x104, clear_branch=1, if_en=1, bpres=0; FLUSH_CYCLES=3 gives three cycles of clear with pop=0; mispred_cnt=1.
- Lane0 JAL, bp=0, jump_en=1, jump_a=0x2000 -> pc_out=0x2000, regfile_en[0]=1, if_en=0.
- rdy_in low for 2 cycles with valid lanes -> pop=0, all enables 0, counters frozen; resumes retiring when rdy_in high.
- rob_valid_in=2'b10 -> pop=0. Reset asserted mid-FLUSH -> clear_branch_out=0 immediately, counters 0.
